video_test_pattern_gen: RTL and testbench
=========================================

# video_test_pattern_gen

Parametrised multi-mode video test-pattern generator for the HDMI/DVI pixel path. It sits between `VideoFormatTiming` and `HdmiEncoder`, replacing the fixed 720p colour-bar source. It produces RGB at configurable colour depth in one of six patterns, including an animated pattern driven by an internal frame counter. All timing/control strobes are delayed so they stay aligned with the pixel data. Pattern changes are applied only at frame boundaries, so a frame never tears.

## Interface
- `COLOR_DEPTH`, 8: bits per colour component (6..12).
- `H_BITS`, 12: width of `hPos`.
- `V_BITS`, 11: width of `vPos`.
- `BAR_WIDTH`, 160: pixels per colour bar.
- `RAMP_SHIFT`, 2: gray-ramp horizontal scale; the ramp advances one level per 2^RAMP_SHIFT pixels.
- `CHECKER_LOG2`, 5: checker square size is 2^CHECKER_LOG2 pixels.
- `MOVE_STEP`, 4: pixels the moving bar advances per frame.
- `MOVE_WIDTH`, 32: moving bar width in pixels.
- `FRAME_BITS`, 8: width of the frame counter.

Ports:
- `pixelClock`  in  1  pixel clock. Only clock domain.
- `asyncResetN`  in  1  asynchronous, active-low reset.
- `dataEnable`, `hSync`, `vSync`  in  1 each  timing from `VideoFormatTiming`.
- `activeVideoGuardBand`, `activeVideoPreamble`  in  1 each  HDMI period markers.
- `hPos`  in  H_BITS  active-pixel x position.
- `vPos`  in  V_BITS  active-line y position.
- `patternSelect`  in  3  requested pattern; latched at frame start.
- `solidColor`  in  3*COLOR_DEPTH  {r,g,b} for the solid pattern.
- `r`, `g`, `b`  out  COLOR_DEPTH each  pixel colour.
- `dataEnableDelayed`, `hSyncDelayed`, `vSyncDelayed`, `activeVideoGuardBandDelayed`, `activeVideoPreambleDelayed`  out  1 each  inputs delayed to match pixel latency.
- `activePattern`  out  3  currently applied pattern.
- `frameCount`  out  FRAME_BITS  frames since reset.

## Operation
- **Frame-start event (FS):** a rising edge of `vSync`, detected against a registered copy of `vSync`.
- **On FS:**
  - `activePattern` <= `patternSelect`.
  - `frameCount` <= `frameCount` + 1, modulo 2^FRAME_BITS.
  - `patternSelect` is ignored at every other time.
- **Bar counter:** a pixel counter `barPix` and a bar index `barIdx` (3 bits, saturating at 7).
  - Both clear while `dataEnable` = 0.
  - While `dataEnable` = 1, `barPix` increments each cycle.
  - When `barPix` = BAR_WIDTH-1, `barPix` returns to 0 and `barIdx` increments.
- **Full scale** F = 2^COLOR_DEPTH-1. **75% level** L = (3*F)>>2 (191 at depth 8).
- **Patterns:**
  - **0, colour bars:** `barIdx` 0..7 gives white, yellow, cyan, green, magenta, red, blue, black. Each component is L or 0.
  - **1, gray ramp:** r=g=b=`hPos`[RAMP_SHIFT+COLOR_DEPTH-1:RAMP_SHIFT], zero-extended if `hPos` is narrower. The value wraps with no saturation.
  - **2, checkerboard:** F on all components if `hPos`[CHECKER_LOG2] XOR `vPos`[CHECKER_LOG2], otherwise 0.
  - **3, solid:** the `solidColor` fields, sampled every pixel (not latched).
  - **4, moving bar:**
    - Left edge E = (`frameCount`*MOVE_STEP) mod 2^H_BITS.
    - White (F) if ((`hPos`-E) mod 2^H_BITS) < MOVE_WIDTH, otherwise 0. The bar wraps across the line edge.
  - **5, vertical gradient:** r = `vPos` scaled as in the gray ramp, g = F - r, b = 0.
  - **6, 7:** black.
- **Blanking:** whenever the stage-1 copy of `dataEnable` = 0, `r`/`g`/`b` = 0, regardless of pattern.

## Timing
- **Pipeline depth:** 2 cycles, identical for pixel data and all `*Delayed` outputs.
  - **Stage 1** registers the inputs, `barIdx` and the pattern decode.
  - **Stage 2** registers the colour.
- **Pattern switch:** a new pattern applies to the first pixel whose stage-1 sample follows FS. `activePattern` updates in the cycle after the `vSync` rise is sampled.
- **Reset values** while `asyncResetN` = 0 (asserted): every output is 0, `activePattern` = 0, `frameCount` = 0, and all pipeline registers and counters are 0.
- **Reset release:** output resumes with a valid, aligned pixel on the 2nd cycle after release. The first FS after release increments `frameCount` to 1.
- **Reset mid-line:** the bar counter restarts from 0 at the next `dataEnable` rise. A partial line is not corrected.
- **Simultaneous FS and `patternSelect` change:** the value sampled in the same cycle as the FS detection is applied.
- **Wrap cases:**
  - `frameCount` wraps 2^FRAME_BITS-1 → 0, and E wraps with it.
  - `barIdx` saturates at 7 (black) on lines longer than 8*BAR_WIDTH.

## Configuration
- **`VIDEO_TEST_PATTERN_ANIMATION_EN` defined:** the frame counter and pattern 4 are compiled in.
- **Undefined:**
  - `frameCount` is tied to 0 and no counter register exists.
  - Pattern 4 outputs black.
  - FS still latches `activePattern`.

## Test plan
- **Colour bars.** Depth 8, 1280-wide active line, pattern 0 → 8 bars of 160 pixels each: FF-less values BF/BF/BF, BF/BF/00, 00/BF/BF, 00/BF/00, BF/00/BF, BF/00/00, 00/00/BF, 00/00/00. Data transitions exactly 2 cycles after the `hPos` transition.
- **Gray ramp.** Pattern 1 with `hPos` = 0, 4, 1020, 1024 → r=g=b = 0, 1, 255, 0 (wrap).
- **Mid-frame select.** `patternSelect` changed 3 → 2 mid-frame → the remainder of the frame stays solid. `activePattern` = 2 and checkerboard output from the first line of the next frame.
- **Moving bar.** Pattern 4 across 3 frames → the bar's left edge is at x = 4, 8, 12. Set `frameCount` to 255 by running 255 frames → E = 1020; pixels 1020..1051 are white across the wrap.
- **Reset.** Assert `asyncResetN` low mid-line in pattern 0 → all outputs are 0 asynchronously. After release, `activePattern` = 0 and the first full line shows correct bars.
- **Alignment.** Random `dataEnable`/`hSync`/`vSync`/guard-band/preamble stimulus → every `*Delayed` output equals its input delayed by 2 cycles, and `r`/`g`/`b` = 0 wherever `dataEnableDelayed` = 0.

Source files
------------

// File: rtl/video_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_test_pattern_gen
// Purpose  : Multi-mode RGB test-pattern source for the HDMI/DVI pixel path.
//            It sits between the format-timing generator and the encoder.
//            Six patterns are available: colour bars, gray ramp, checkerboard,
//            solid, moving bar and vertical gradient. All timing strobes are
//            delayed to stay aligned with the 2-stage pixel pipeline.
//            Pattern changes take effect only at frame start (rising vSync).
// Ports    : pixelClock, asyncResetN       clock / async active-low reset
//            dataEnable, hSync, vSync,
//            activeVideoGuardBand,
//            activeVideoPreamble           timing inputs
//            hPos, vPos                    active pixel position
//            patternSelect                 requested pattern (latched at FS)
//            solidColor                    {r,g,b} for the solid pattern
//            r, g, b                       pixel colour (2-cycle latency)
//            *Delayed                      timing inputs delayed by 2 cycles
//            activePattern                 pattern currently applied
//            frameCount                    frames since reset
// Macro    : VIDEO_TEST_PATTERN_ANIMATION_EN enables the frame counter and
//            the moving-bar pattern. When undefined, frameCount is 0 and
//            pattern 4 is black.
// Revision : 1.0 - initial release
// ============================================================================
module video_test_pattern_gen #(
  parameter int COLOR_DEPTH  = 8,
  parameter int H_BITS       = 12,
  parameter int V_BITS       = 11,
  parameter int BAR_WIDTH    = 160,
  parameter int RAMP_SHIFT   = 2,
  parameter int CHECKER_LOG2 = 5,
  parameter int MOVE_STEP    = 4,
  parameter int MOVE_WIDTH   = 32,
  parameter int FRAME_BITS   = 8
) (
  input  logic                     pixelClock,
  input  logic                     asyncResetN,
  input  logic                     dataEnable,
  input  logic                     hSync,
  input  logic                     vSync,
  input  logic                     activeVideoGuardBand,
  input  logic                     activeVideoPreamble,
  input  logic [H_BITS-1:0]        hPos,
  input  logic [V_BITS-1:0]        vPos,
  input  logic [2:0]               patternSelect,
  input  logic [3*COLOR_DEPTH-1:0] solidColor,
  output logic [COLOR_DEPTH-1:0]   r,
  output logic [COLOR_DEPTH-1:0]   g,
  output logic [COLOR_DEPTH-1:0]   b,
  output logic                     dataEnableDelayed,
  output logic                     hSyncDelayed,
  output logic                     vSyncDelayed,
  output logic                     activeVideoGuardBandDelayed,
  output logic                     activeVideoPreambleDelayed,
  output logic [2:0]               activePattern,
  output logic [FRAME_BITS-1:0]    frameCount
);

  localparam logic [2:0] c_pat_bars    = 3'd0;
  localparam logic [2:0] c_pat_ramp    = 3'd1;
  localparam logic [2:0] c_pat_checker = 3'd2;
  localparam logic [2:0] c_pat_solid   = 3'd3;
  localparam logic [2:0] c_pat_moving  = 3'd4;
  localparam logic [2:0] c_pat_vgrad   = 3'd5;

  localparam logic [COLOR_DEPTH-1:0] c_full  = {COLOR_DEPTH{1'b1}};
  localparam logic [COLOR_DEPTH-1:0] c_level =
    COLOR_DEPTH'((3 * ((1 << COLOR_DEPTH) - 1)) >> 2);

  localparam int c_pix_bits = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [c_pix_bits-1:0] c_bar_last = c_pix_bits'(BAR_WIDTH - 1);

  // Stage-1 registers
  logic                     de_s1, hs_s1, vs_s1, gb_s1, pre_s1;
  logic [H_BITS-1:0]        hpos_s1;
  logic [V_BITS-1:0]        vpos_s1;
  logic [2:0]               bar_idx_s1;
  logic [2:0]               pattern_s1;
  logic [3*COLOR_DEPTH-1:0] solid_s1;
  logic [H_BITS-1:0]        move_edge_s1;

  // Bar counter: holds the position of the pixel currently on the inputs,
  // so its value is captured into stage 1 alongside that pixel.
  logic [c_pix_bits-1:0] bar_pix;
  logic [2:0]            bar_idx;

  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (!dataEnable) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_pix == c_bar_last) begin
      bar_pix <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pix <= bar_pix + c_pix_bits'(1);
    end
  end

  // Frame start: vSync rising against its stage-1 copy.
  logic frame_start;
  assign frame_start = vSync & ~vs_s1;

  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) activePattern <= '0;
    else if (frame_start) activePattern <= patternSelect;
  end

`ifdef VIDEO_TEST_PATTERN_ANIMATION_EN
  localparam logic c_anim_en = 1'b1;

  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) frameCount <= '0;
    else if (frame_start) frameCount <= frameCount + FRAME_BITS'(1);
  end
`else
  localparam logic c_anim_en = 1'b0;

  assign frameCount = '0;
`endif

  // Left edge of the moving bar, modulo the line-position width.
  logic [H_BITS-1:0] move_edge;
  assign move_edge = H_BITS'(frameCount) * H_BITS'(MOVE_STEP);

  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      de_s1        <= 1'b0;
      hs_s1        <= 1'b0;
      vs_s1        <= 1'b0;
      gb_s1        <= 1'b0;
      pre_s1       <= 1'b0;
      hpos_s1      <= '0;
      vpos_s1      <= '0;
      bar_idx_s1   <= '0;
      pattern_s1   <= '0;
      solid_s1     <= '0;
      move_edge_s1 <= '0;
    end else begin
      de_s1        <= dataEnable;
      hs_s1        <= hSync;
      vs_s1        <= vSync;
      gb_s1        <= activeVideoGuardBand;
      pre_s1       <= activeVideoPreamble;
      hpos_s1      <= hPos;
      vpos_s1      <= vPos;
      bar_idx_s1   <= bar_idx;
      pattern_s1   <= activePattern;
      solid_s1     <= solidColor;
      move_edge_s1 <= move_edge;
    end
  end

  // Stage-2 colour generation. Zero-extension before the shift covers
  // position inputs narrower than RAMP_SHIFT+COLOR_DEPTH.
  logic [COLOR_DEPTH-1:0] h_ramp, v_ramp;
  logic [H_BITS-1:0]      move_off;
  logic                   in_moving_bar;

  assign h_ramp        = COLOR_DEPTH'({{COLOR_DEPTH{1'b0}}, hpos_s1} >> RAMP_SHIFT);
  assign v_ramp        = COLOR_DEPTH'({{COLOR_DEPTH{1'b0}}, vpos_s1} >> RAMP_SHIFT);
  assign move_off      = hpos_s1 - move_edge_s1;
  assign in_moving_bar = c_anim_en & (move_off < H_BITS'(MOVE_WIDTH));

  logic [COLOR_DEPTH-1:0] red_next, green_next, blue_next;

  always_comb begin
    red_next   = '0;
    green_next = '0;
    blue_next  = '0;
    if (de_s1) begin
      case (pattern_s1)
        c_pat_bars: begin
          // Bar order white,yellow,cyan,green,magenta,red,blue,black maps
          // each component to one inverted bit of the bar index.
          red_next   = {COLOR_DEPTH{~bar_idx_s1[1]}} & c_level;
          green_next = {COLOR_DEPTH{~bar_idx_s1[2]}} & c_level;
          blue_next  = {COLOR_DEPTH{~bar_idx_s1[0]}} & c_level;
        end
        c_pat_ramp: begin
          red_next   = h_ramp;
          green_next = h_ramp;
          blue_next  = h_ramp;
        end
        c_pat_checker: begin
          if (hpos_s1[CHECKER_LOG2] ^ vpos_s1[CHECKER_LOG2]) begin
            red_next   = c_full;
            green_next = c_full;
            blue_next  = c_full;
          end
        end
        c_pat_solid: begin
          red_next   = solid_s1[3*COLOR_DEPTH-1 -: COLOR_DEPTH];
          green_next = solid_s1[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
          blue_next  = solid_s1[COLOR_DEPTH-1:0];
        end
        c_pat_moving: begin
          if (in_moving_bar) begin
            red_next   = c_full;
            green_next = c_full;
            blue_next  = c_full;
          end
        end
        c_pat_vgrad: begin
          red_next   = v_ramp;
          green_next = c_full - v_ramp;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      r                           <= '0;
      g                           <= '0;
      b                           <= '0;
      dataEnableDelayed           <= 1'b0;
      hSyncDelayed                <= 1'b0;
      vSyncDelayed                <= 1'b0;
      activeVideoGuardBandDelayed <= 1'b0;
      activeVideoPreambleDelayed  <= 1'b0;
    end else begin
      r                           <= red_next;
      g                           <= green_next;
      b                           <= blue_next;
      dataEnableDelayed           <= de_s1;
      hSyncDelayed                <= hs_s1;
      vSyncDelayed                <= vs_s1;
      activeVideoGuardBandDelayed <= gb_s1;
      activeVideoPreambleDelayed  <= pre_s1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_test_pattern_gen
// Purpose  : Self-checking bench for video_test_pattern_gen at default
//            parameters (depth 8, 12-bit hPos, 11-bit vPos). A behavioural
//            model predicts every output each cycle; directed vectors pin
//            the model with hand-computed literals. Adapts to the
//            VIDEO_TEST_PATTERN_ANIMATION_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_test_pattern_gen;

`ifdef VIDEO_TEST_PATTERN_ANIMATION_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dataEnable = 1'b0, hSync = 1'b0, vSync = 1'b0;
  logic        activeVideoGuardBand = 1'b0, activeVideoPreamble = 1'b0;
  logic [11:0] hPos = '0;
  logic [10:0] vPos = '0;
  logic [2:0]  patternSelect = '0;
  logic [23:0] solidColor = '0;
  logic [7:0]  r, g, b;
  logic        dataEnableDelayed, hSyncDelayed, vSyncDelayed;
  logic        activeVideoGuardBandDelayed, activeVideoPreambleDelayed;
  logic [2:0]  activePattern;
  logic [7:0]  frameCount;

  always #5 clk = ~clk;

  video_test_pattern_gen dut (
    .pixelClock                  (clk),
    .asyncResetN                 (rst_n),
    .dataEnable                  (dataEnable),
    .hSync                       (hSync),
    .vSync                       (vSync),
    .activeVideoGuardBand        (activeVideoGuardBand),
    .activeVideoPreamble         (activeVideoPreamble),
    .hPos                        (hPos),
    .vPos                        (vPos),
    .patternSelect               (patternSelect),
    .solidColor                  (solidColor),
    .r                           (r),
    .g                           (g),
    .b                           (b),
    .dataEnableDelayed           (dataEnableDelayed),
    .hSyncDelayed                (hSyncDelayed),
    .vSyncDelayed                (vSyncDelayed),
    .activeVideoGuardBandDelayed (activeVideoGuardBandDelayed),
    .activeVideoPreambleDelayed  (activeVideoPreambleDelayed),
    .activePattern               (activePattern),
    .frameCount                  (frameCount)
  );

  int asserts = 0;
  int fails   = 0;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic de, hs, vs, gb, pre;
  } px_t;

  // ---------------- behavioural model ----------------
  // Colour bars as {R,G,B} on/off masks, white..black.
  logic [2:0] bar_mask [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                               3'b101, 3'b100, 3'b001, 3'b000};

  function automatic px_t model_pixel(input logic de, hs, vs, gb, pre,
                                      input int h, v, input int pat,
                                      input int fc, run, input logic [23:0] solid);
    px_t p;
    int lvl, idx, e, off, rv, val;
    logic [2:0] m;
    p = '0;
    p.de = de; p.hs = hs; p.vs = vs; p.gb = gb; p.pre = pre;
    lvl = (3 * 255) / 4;
    if (de) begin
      case (pat)
        0: begin
          idx = run / 160;
          if (idx > 7) idx = 7;
          m = bar_mask[idx];
          p.r = m[2] ? 8'(lvl) : 8'd0;
          p.g = m[1] ? 8'(lvl) : 8'd0;
          p.b = m[0] ? 8'(lvl) : 8'd0;
        end
        1: begin
          val = (h / 4) % 256;
          p.r = 8'(val); p.g = 8'(val); p.b = 8'(val);
        end
        2: if ((((h / 32) + (v / 32)) % 2) == 1) begin
          p.r = 8'd255; p.g = 8'd255; p.b = 8'd255;
        end
        3: begin
          p.r = solid[23:16]; p.g = solid[15:8]; p.b = solid[7:0];
        end
        4: if (ANIM) begin
          e   = (fc * 4) % 4096;
          off = (h - e + 4096) % 4096;
          if (off < 32) begin
            p.r = 8'd255; p.g = 8'd255; p.b = 8'd255;
          end
        end
        5: begin
          rv  = (v / 4) % 256;
          p.r = 8'(rv);
          p.g = 8'(255 - rv);
        end
        default: ;
      endcase
    end
    return p;
  endfunction

  px_t  hold, expo;
  int   m_run, m_pat, m_fc;
  logic m_vs_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold = '0; expo = '0; m_run = 0; m_pat = 0; m_fc = 0; m_vs_prev = 1'b0;
    end else begin
      expo = hold;
      hold = model_pixel(dataEnable, hSync, vSync, activeVideoGuardBand,
                         activeVideoPreamble, int'(hPos), int'(vPos),
                         m_pat, m_fc, m_run, solidColor);
      if (dataEnable) m_run = m_run + 1;
      else            m_run = 0;
      if (vSync && !m_vs_prev) begin
        m_pat = int'(patternSelect);
        if (ANIM) m_fc = (m_fc + 1) % 256;
      end
      m_vs_prev = vSync;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    px_t got;
    #1;
    got = {r, g, b, dataEnableDelayed, hSyncDelayed, vSyncDelayed,
           activeVideoGuardBandDelayed, activeVideoPreambleDelayed};
    asserts++;
    if (got !== expo || activePattern !== 3'(m_pat) || frameCount !== 8'(m_fc)) begin
      fails++;
      $display("FAIL cycle t=%0t got rgb=%h flags=%b pat=%0d fc=%0d required rgb=%h flags=%b pat=%0d fc=%0d",
               $time, got[28:5], got[4:0], activePattern, frameCount,
               expo[28:5], expo[4:0], m_pat, m_fc);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    asserts++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic frame_start(input logic [2:0] sel);
    patternSelect = sel;
    vSync = 1'b1;
    tick();
    vSync = 1'b0;
    tick();
  endtask

  // Single active pixel, colour checked after the 2-cycle latency.
  task automatic pix_check(input logic [11:0] h, input logic [10:0] v,
                           input logic [23:0] want, input string name);
    hPos = h; vPos = v; dataEnable = 1'b1;
    tick();
    dataEnable = 1'b0;
    @(posedge clk);
    #1;
    check(name, 32'({r, g, b}), 32'(want));
    #1;
  endtask

  logic [23:0] bar_lit [8] = '{24'hBFBFBF, 24'hBFBF00, 24'h00BFBF, 24'h00BF00,
                               24'hBF00BF, 24'hBF0000, 24'h0000BF, 24'h000000};
  logic [23:0] cap [1280];

  task automatic run_bar_line(input string tag);
    vPos = 11'd10;
    for (int x = 0; x < 1280; x++) begin
      if (x >= 2) cap[x-2] = {r, g, b};
      hPos = 12'(x); dataEnable = 1'b1;
      tick();
    end
    cap[1278] = {r, g, b};
    dataEnable = 1'b0;
    tick();
    cap[1279] = {r, g, b};
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_first_%0d", tag, i), 32'(cap[i*160]), 32'(bar_lit[i]));
      check($sformatf("%s_last_%0d", tag, i), 32'(cap[i*160+159]), 32'(bar_lit[i]));
    end
  endtask

  logic [4:0] hist [400];

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_rgb", 32'({r, g, b}), 32'(0));
    check("reset_flags", 32'({dataEnableDelayed, hSyncDelayed, vSyncDelayed,
          activeVideoGuardBandDelayed, activeVideoPreambleDelayed}), 32'(0));
    check("reset_pattern", 32'(activePattern), 32'(0));
    check("reset_framecount", 32'(frameCount), 32'(0));
    rst_n = 1'b1;
    tick(); tick();

    // Colour bars
    frame_start(3'd0);
    check("fc_first_fs", 32'(frameCount), ANIM ? 32'(1) : 32'(0));
    run_bar_line("bars");

    // Gray ramp
    frame_start(3'd1);
    pix_check(12'd0,    11'd0, 24'h000000, "ramp_0");
    pix_check(12'd4,    11'd0, 24'h010101, "ramp_4");
    pix_check(12'd1020, 11'd0, 24'hFFFFFF, "ramp_1020");
    pix_check(12'd1024, 11'd0, 24'h000000, "ramp_1024_wrap");

    // Mid-frame select: solid holds until the next frame start
    solidColor = 24'h123456;
    frame_start(3'd3);
    pix_check(12'd100, 11'd5, 24'h123456, "solid_a");
    patternSelect = 3'd2;
    pix_check(12'd200, 11'd6, 24'h123456, "solid_after_select");
    check("pattern_held", 32'(activePattern), 32'(3));
    frame_start(3'd2);
    check("pattern_switched", 32'(activePattern), 32'(2));
    pix_check(12'd32, 11'd0,  24'hFFFFFF, "checker_32_0");
    pix_check(12'd32, 11'd32, 24'h000000, "checker_32_32");
    pix_check(12'd0,  11'd32, 24'hFFFFFF, "checker_0_32");
    pix_check(12'd31, 11'd31, 24'h000000, "checker_31_31");

    // Vertical gradient: vPos 400 -> 100 = 0x64, green 0x9B
    frame_start(3'd5);
    pix_check(12'd7, 11'd400, 24'h649B00, "vgrad_400");

    // Reset mid-line in pattern 0
    frame_start(3'd0);
    vPos = 11'd3;
    for (int x = 0; x < 100; x++) begin
      hPos = 12'(x); dataEnable = 1'b1;
      tick();
    end
    check("pre_reset_rgb", 32'({r, g, b}), 32'(24'hBFBFBF));
    rst_n = 1'b0;
    #1;
    check("async_reset_rgb", 32'({r, g, b}), 32'(0));
    check("async_reset_de", 32'(dataEnableDelayed), 32'(0));
    check("async_reset_fc", 32'(frameCount), 32'(0));
    #1;
    dataEnable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_reset_pattern", 32'(activePattern), 32'(0));
    run_bar_line("bars_after_reset");

    // Moving bar
`ifdef VIDEO_TEST_PATTERN_ANIMATION_EN
    frame_start(3'd4);
    check("move_fc1", 32'(frameCount), 32'(1));
    pix_check(12'd3,  11'd0, 24'h000000, "move1_3");
    pix_check(12'd4,  11'd0, 24'hFFFFFF, "move1_4");
    pix_check(12'd35, 11'd0, 24'hFFFFFF, "move1_35");
    pix_check(12'd36, 11'd0, 24'h000000, "move1_36");
    frame_start(3'd4);
    pix_check(12'd7,  11'd0, 24'h000000, "move2_7");
    pix_check(12'd8,  11'd0, 24'hFFFFFF, "move2_8");
    frame_start(3'd4);
    pix_check(12'd11, 11'd0, 24'h000000, "move3_11");
    pix_check(12'd12, 11'd0, 24'hFFFFFF, "move3_12");
    pix_check(12'd43, 11'd0, 24'hFFFFFF, "move3_43");
    pix_check(12'd44, 11'd0, 24'h000000, "move3_44");
    repeat (252) frame_start(3'd4);
    check("move_fc255", 32'(frameCount), 32'(255));
    pix_check(12'd1019, 11'd0, 24'h000000, "move255_1019");
    pix_check(12'd1020, 11'd0, 24'hFFFFFF, "move255_1020");
    pix_check(12'd1051, 11'd0, 24'hFFFFFF, "move255_1051");
    pix_check(12'd1052, 11'd0, 24'h000000, "move255_1052");
    frame_start(3'd4);
    check("move_fc_wrap", 32'(frameCount), 32'(0));
    pix_check(12'd0,    11'd0, 24'hFFFFFF, "move0_0");
    pix_check(12'd31,   11'd0, 24'hFFFFFF, "move0_31");
    pix_check(12'd32,   11'd0, 24'h000000, "move0_32");
    pix_check(12'd4095, 11'd0, 24'h000000, "move0_4095");
`else
    frame_start(3'd4);
    check("noanim_pattern", 32'(activePattern), 32'(4));
    pix_check(12'd0, 11'd0, 24'h000000, "noanim_0");
    pix_check(12'd4, 11'd0, 24'h000000, "noanim_4");
    repeat (10) frame_start(3'd4);
    check("noanim_fc", 32'(frameCount), 32'(0));
`endif

    // Alignment under random timing stimulus
    for (int i = 0; i < 400; i++) begin
      if (i >= 2) begin
        check($sformatf("align_%0d", i),
              32'({dataEnableDelayed, hSyncDelayed, vSyncDelayed,
                   activeVideoGuardBandDelayed, activeVideoPreambleDelayed}),
              32'(hist[i-2]));
        if (!dataEnableDelayed) check($sformatf("blank_%0d", i), 32'({r, g, b}), 32'(0));
      end
      dataEnable           = 1'($urandom);
      hSync                = 1'($urandom);
      vSync                = ($urandom_range(0, 7) == 0);
      activeVideoGuardBand = 1'($urandom);
      activeVideoPreamble  = 1'($urandom);
      hPos                 = 12'($urandom);
      vPos                 = 11'($urandom);
      patternSelect        = 3'($urandom);
      solidColor           = 24'($urandom);
      hist[i] = {dataEnable, hSync, vSync, activeVideoGuardBand, activeVideoPreamble};
      tick();
    end

    dataEnable = 1'b0; hSync = 1'b0; vSync = 1'b0;
    activeVideoGuardBand = 1'b0; activeVideoPreamble = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
